// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline control state encoding and drain-length helper.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } pipe_state_t;

    // The HLT has to travel from the branch stage to WB before the pipe is empty.
    function automatic int drainLength(input int numStages, input int brStage);
        return numStages - 2 - brStage;
    endfunction

endpackage

// File: rtl/pipe_halt_fsm.sv
// Halt sequencer: RUN -> DRAIN -> HALTED, with a counter that tracks the HLT
// walking from the branch stage down to WB.
module pipe_halt_fsm
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        goDrain,
    input  logic        memBusy,
    output pipe_state_t state,
    output logic        hlt
);

    localparam int CNT_W = $clog2(NUM_STAGES);
    localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(drainLength(NUM_STAGES, BR_STAGE));

    logic [CNT_W-1:0] drainCnt;

    // A memory stall freezes the HLT in place, so the counter only advances
    // on cycles where the memory stage moves forward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            drainCnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (goDrain) begin
                        state    <= DRAIN;
                        drainCnt <= DRAIN_LOAD;
                    end
                end
                DRAIN: begin
                    if (drainCnt == '0) begin
                        state <= HALTED;
                    end else if (!memBusy) begin
                        drainCnt <= drainCnt - 1'b1;
                    end
                end
                HALTED: begin
                    state <= HALTED;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign hlt = (state == HALTED);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: register enables, bubble insertion, PC write enable,
// per-stage valid bits and the halt/drain sequence for the in-order CPU.
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int BR_STAGE   = 1,
    parameter int LU_STAGE   = 1,
    parameter int MEM_STAGE  = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_use,
    input  logic                  branch_take,
    input  logic                  mem_busy,
    input  logic                  halt_dec,
    output logic                  pc_wen,
    output logic [NUM_STAGES-2:0] stage_wen,
    output logic [NUM_STAGES-2:0] stage_clr,
    output logic [NUM_STAGES-1:0] valid,
    output logic [1:0]            state,
    output logic                  hlt
);

    pipe_state_t           fsmState;
    logic [NUM_STAGES-1:1] validReg;
    logic [NUM_STAGES-1:0] validAll;
    logic [NUM_STAGES-2:0] wenVec;
    logic [NUM_STAGES-2:0] clrVec;
    logic                  pcWenC;
    logic                  luQ;
    logic                  btQ;
    logic                  hdQ;
    logic                  goDrain;

    assign validAll = {validReg, (fsmState == RUN)};
    assign luQ      = load_use    & validAll[LU_STAGE];
    assign btQ      = branch_take & validAll[BR_STAGE];
    assign hdQ      = halt_dec    & validAll[BR_STAGE];
    assign goDrain  = hdQ & ~mem_busy & ~luQ & ~btQ & (fsmState == RUN);

    // Stall/flush decode in priority order mem_busy > load-use > branch;
    // stages below the stalled register hold, the stalled register emits a bubble.
    always_comb begin
        pcWenC = 1'b0;
        wenVec = '0;
        clrVec = '0;
        if (fsmState != HALTED) begin
            if (mem_busy) begin
                for (int r = 0; r < NUM_STAGES - 1; r++) begin
                    wenVec[r] = (r >= MEM_STAGE);
                end
                clrVec[MEM_STAGE] = 1'b1;
            end else if (luQ) begin
                for (int r = 0; r < NUM_STAGES - 1; r++) begin
                    wenVec[r] = (r >= LU_STAGE);
                end
                clrVec[LU_STAGE] = 1'b1;
            end else if (btQ && (fsmState == RUN)) begin
                pcWenC = 1'b1;
                wenVec = '1;
                for (int r = 0; r < NUM_STAGES - 1; r++) begin
                    clrVec[r] = (r < BR_STAGE);
                end
            end else begin
                pcWenC = (fsmState == RUN);
                wenVec = '1;
            end
            if (fsmState == DRAIN) begin
                clrVec[0] = 1'b1;
            end
        end
    end

    // Each valid bit follows its instruction through the pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validReg <= '0;
        end else begin
            for (int r = 0; r < NUM_STAGES - 1; r++) begin
                if (wenVec[r]) begin
                    validReg[r+1] <= validAll[r] & ~clrVec[r];
                end
            end
        end
    end

    pipe_halt_fsm #(
        .NUM_STAGES (NUM_STAGES),
        .BR_STAGE   (BR_STAGE)
    ) haltFsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .goDrain (goDrain),
        .memBusy (mem_busy),
        .state   (fsmState),
        .hlt     (hlt)
    );

    assign pc_wen    = pcWenC;
    assign stage_wen = wenVec;
    assign stage_clr = clrVec;
    assign valid     = validAll;
    assign state     = fsmState;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed per-cycle vectors push expectations,
// a monitor on the falling edge pops and compares them.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_use = 1'b0;
    logic       branch_take = 1'b0;
    logic       mem_busy = 1'b0;
    logic       halt_dec = 1'b0;

    logic       pcWenA;
    logic [3:0] wenA;
    logic [3:0] clrA;
    logic [4:0] validA;
    logic [1:0] stateA;
    logic       hltA;

    logic       pcWen7;
    logic [5:0] wen7;
    logic [5:0] clr7;
    logic [6:0] valid7;
    logic [1:0] state7;
    logic       hlt7;

    int nVectors = 0;
    int nMiss    = 0;

    typedef struct {
        string      tag;
        bit         isBig;
        logic       pcWen;
        logic [3:0] wen;
        logic [3:0] clr;
        logic [4:0] vld;
        logic [1:0] st;
        logic       hlt;
        logic [5:0] care;
    } exp_t;

    exp_t sbQ[$];

    localparam logic [1:0] S_RUN = 2'b00;
    localparam logic [1:0] S_DRN = 2'b01;
    localparam logic [1:0] S_HLT = 2'b10;

    localparam logic [5:0] ALL   = 6'h3F;
    localparam logic [5:0] NOCLR = 6'h3B;
    localparam logic [5:0] BIG   = 6'h31;

    // {rst_n, mem_busy, load_use, branch_take, halt_dec}
    localparam logic [4:0] I_RST  = 5'b00000;
    localparam logic [4:0] I_IDLE = 5'b10000;
    localparam logic [4:0] I_LU   = 5'b10100;
    localparam logic [4:0] I_LUBT = 5'b10110;
    localparam logic [4:0] I_BT   = 5'b10010;
    localparam logic [4:0] I_MB   = 5'b11000;
    localparam logic [4:0] I_HD   = 5'b10001;

    pipe_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_use    (load_use),
        .branch_take (branch_take),
        .mem_busy    (mem_busy),
        .halt_dec    (halt_dec),
        .pc_wen      (pcWenA),
        .stage_wen   (wenA),
        .stage_clr   (clrA),
        .valid       (validA),
        .state       (stateA),
        .hlt         (hltA)
    );

    pipe_ctrl #(
        .NUM_STAGES (7),
        .BR_STAGE   (2),
        .LU_STAGE   (1),
        .MEM_STAGE  (4)
    ) dut7 (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_use    (load_use),
        .branch_take (branch_take),
        .mem_busy    (mem_busy),
        .halt_dec    (halt_dec),
        .pc_wen      (pcWen7),
        .stage_wen   (wen7),
        .stage_clr   (clr7),
        .valid       (valid7),
        .state       (state7),
        .hlt         (hlt7)
    );

    always #5 clk = ~clk;

    // Drives one cycle of inputs just after the rising edge and queues what the
    // outputs must show before the next edge.
    task automatic applyStimulus(input string tag, input logic [4:0] stim, input bit isBig,
                                 input logic pc, input logic [3:0] wen, input logic [3:0] clr,
                                 input logic [4:0] vld, input logic [1:0] st, input logic h,
                                 input logic [5:0] care);
        exp_t e;
        @(posedge clk);
        #1;
        {rst_n, mem_busy, load_use, branch_take, halt_dec} = stim;
        e.tag   = tag;
        e.isBig = isBig;
        e.pcWen = pc;
        e.wen   = wen;
        e.clr   = clr;
        e.vld   = vld;
        e.st    = st;
        e.hlt   = h;
        e.care  = care;
        sbQ.push_back(e);
    endtask

    task automatic compareField(input string tag, input string field,
                                input logic [7:0] got, input logic [7:0] want);
        nVectors++;
        if (got !== want) begin
            nMiss++;
            $display("[TB] FAIL %s %s got %b want %b", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        if (e.isBig) begin
            if (e.care[0]) compareField(e.tag, "pc_wen7", {7'b0, pcWen7}, {7'b0, e.pcWen});
            if (e.care[4]) compareField(e.tag, "state7", {6'b0, state7}, {6'b0, e.st});
            if (e.care[5]) compareField(e.tag, "hlt7", {7'b0, hlt7}, {7'b0, e.hlt});
        end else begin
            if (e.care[0]) compareField(e.tag, "pc_wen", {7'b0, pcWenA}, {7'b0, e.pcWen});
            if (e.care[1]) compareField(e.tag, "stage_wen", {4'b0, wenA}, {4'b0, e.wen});
            if (e.care[2]) compareField(e.tag, "stage_clr", {4'b0, clrA}, {4'b0, e.clr});
            if (e.care[3]) compareField(e.tag, "valid", {3'b0, validA}, {3'b0, e.vld});
            if (e.care[4]) compareField(e.tag, "state", {6'b0, stateA}, {6'b0, e.st});
            if (e.care[5]) compareField(e.tag, "hlt", {7'b0, hltA}, {7'b0, e.hlt});
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset and idle ramp
        applyStimulus("reset",  I_RST,  0, 1, 4'b1111, 4'b0000, 5'b00001, S_RUN, 0, ALL);
        applyStimulus("idle1",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00001, S_RUN, 0, ALL);
        applyStimulus("idle2",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00011, S_RUN, 0, ALL);
        applyStimulus("idle3",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00111, S_RUN, 0, ALL);
        applyStimulus("idle4",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("idle5",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("idle6",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        // Load-use bubble walks to WB
        applyStimulus("lu",     I_LU,   0, 0, 4'b1110, 4'b0010, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("lu+1",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11011, S_RUN, 0, ALL);
        applyStimulus("lu+2",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b10111, S_RUN, 0, ALL);
        applyStimulus("lu+3",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("lu+4",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        // Load-use beats branch, branch resolves the cycle after
        applyStimulus("lubt",   I_LUBT, 0, 0, 4'b1110, 4'b0010, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("bt",     I_BT,   0, 1, 4'b1111, 4'b0001, 5'b11011, S_RUN, 0, ALL);
        applyStimulus("bt+1",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b10101, S_RUN, 0, ALL);
        applyStimulus("bt+2",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b01011, S_RUN, 0, ALL);
        applyStimulus("bt+3",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b10111, S_RUN, 0, ALL);
        applyStimulus("bt+4",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("bt+5",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        // Three-cycle memory stall
        applyStimulus("mb1",    I_MB,   0, 0, 4'b1000, 4'b1000, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("mb2",    I_MB,   0, 0, 4'b1000, 4'b1000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("mb3",    I_MB,   0, 0, 4'b1000, 4'b1000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("mb+1",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("mb+2",   I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        // Halt with a memory stall in the middle of the drain
        applyStimulus("hd",     I_HD,   0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("drn1",   I_IDLE, 0, 0, 4'b1111, 4'b0001, 5'b11110, S_DRN, 0, ALL);
        applyStimulus("drn2mb", I_MB,   0, 0, 4'b1000, 4'b0000, 5'b11100, S_DRN, 0, NOCLR);
        applyStimulus("drn3",   I_IDLE, 0, 0, 4'b1111, 4'b0001, 5'b01100, S_DRN, 0, ALL);
        applyStimulus("drn4",   I_IDLE, 0, 0, 4'b1111, 4'b0001, 5'b11000, S_DRN, 0, ALL);
        applyStimulus("halt1",  I_IDLE, 0, 0, 4'b0000, 4'b0000, 5'b10000, S_HLT, 1, NOCLR);
        applyStimulus("halt2",  I_MB,   0, 0, 4'b0000, 4'b0000, 5'b10000, S_HLT, 1, NOCLR);
        // Reset out of HALTED, refill, then reset in the middle of a drain
        applyStimulus("rstH",   I_RST,  0, 1, 4'b1111, 4'b0000, 5'b00001, S_RUN, 0, ALL);
        applyStimulus("fill1",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00001, S_RUN, 0, ALL);
        applyStimulus("fill2",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00011, S_RUN, 0, ALL);
        applyStimulus("fill3",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00111, S_RUN, 0, ALL);
        applyStimulus("fill4",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b01111, S_RUN, 0, ALL);
        applyStimulus("fill5",  I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("hd2",    I_HD,   0, 1, 4'b1111, 4'b0000, 5'b11111, S_RUN, 0, ALL);
        applyStimulus("drnB1",  I_IDLE, 0, 0, 4'b1111, 4'b0001, 5'b11110, S_DRN, 0, ALL);
        applyStimulus("rstD",   I_RST,  0, 1, 4'b1111, 4'b0000, 5'b00001, S_RUN, 0, ALL);
        // HLT decoded with nothing valid in the branch stage is ignored
        applyStimulus("hdInv",  I_HD,   0, 1, 4'b1111, 4'b0000, 5'b00001, S_RUN, 0, ALL);
        applyStimulus("hdInv+", I_IDLE, 0, 1, 4'b1111, 4'b0000, 5'b00011, S_RUN, 0, ALL);
        // Seven-stage pipe, branch stage 2, memory stall one cycle into the drain
        applyStimulus("b7run",  I_IDLE, 1, 1, 4'b0000, 4'b0000, 5'b00000, S_RUN, 0, BIG);
        applyStimulus("b7hd",   I_HD,   1, 1, 4'b0000, 4'b0000, 5'b00000, S_RUN, 0, BIG);
        applyStimulus("b7d1",   I_IDLE, 1, 0, 4'b0000, 4'b0000, 5'b00000, S_DRN, 0, BIG);
        applyStimulus("b7d2mb", I_MB,   1, 0, 4'b0000, 4'b0000, 5'b00000, S_DRN, 0, BIG);
        applyStimulus("b7d3",   I_IDLE, 1, 0, 4'b0000, 4'b0000, 5'b00000, S_DRN, 0, BIG);
        applyStimulus("b7d4",   I_IDLE, 1, 0, 4'b0000, 4'b0000, 5'b00000, S_DRN, 0, BIG);
        applyStimulus("b7d5",   I_IDLE, 1, 0, 4'b0000, 4'b0000, 5'b00000, S_DRN, 0, BIG);
        applyStimulus("b7hlt",  I_IDLE, 1, 0, 4'b0000, 4'b0000, 5'b00000, S_HLT, 1, BIG);
        applyStimulus("b7hlt2", I_IDLE, 1, 0, 4'b0000, 4'b0000, 5'b00000, S_HLT, 1, BIG);

        repeat (2) @(posedge clk);
        #1;
        nVectors++;
        if (sbQ.size() != 0) begin
            nMiss++;
            $display("[TB] FAIL scoreboard got %0d pending want 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
        $finish;
    end

endmodule
